uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, 8N1 framing: 1 start bit (0), 8 data bits, 1 stop bit (1); line idles high.
- Samples the asynchronous serial input at mid-bit using a clock-cycle counter. Presents each received byte on a valid/ready interface to downstream logic, such as a command parser or a loopback path to the transmitter.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 6, fpga_clk cycles per bit period; must be >= 4. HALF_BIT = CLKS_PER_BIT/2, using integer division.
- MSB_FIRST, 1, 1 = first data bit on the line is dout[7]; 0 = first data bit is dout[0].

Ports:
- fpga_clk, input, 1, system clock.
- nrst, input, 1, synchronous active-low reset.
- sin, input, 1, asynchronous serial line.
- rx_ready, input, 1, consumer accepts dout while rx_valid=1.
- dout, output, 8, received byte; stable while rx_valid=1.
- rx_valid, output, 1, byte available.
- frame_err, output, 1, 1-cycle pulse when the stop bit is sampled as 0.
- overrun, output, 1, 1-cycle pulse when a good frame completes while rx_valid=1 and rx_ready=0.
- busy_rx, output, 1, high in any state except IDLE.

Behaviour:
- Interface: reset nrst, synchronous, active-low; clock fpga_clk.
- Reset values (nrst=0 at a clock edge): state=IDLE, dout=8'h00, rx_valid=0, frame_err=0, overrun=0, busy_rx=0, sync flops=1, counters=0. Reset mid-frame abandons the frame with no flags raised.
- Input synchronizer: sin passes through 2 flops to produce s. An edge detector flop holds s_d (previous s). All decisions use s.
- Counters: tick_cnt counts 0..CLKS_PER_BIT-1; bit_cnt counts 0..7.
- State machine:
  - IDLE: s_d=1 and s=0 (falling edge) -> START, tick_cnt=0.
  - START: when tick_cnt==HALF_BIT-1, sample s.
    - s=1: glitch -> IDLE, no flags.
    - s=0: -> DATA, tick_cnt=0, bit_cnt=0.
  - DATA: when tick_cnt==CLKS_PER_BIT-1, sample s into the shift register and tick_cnt=0.
    - MSB_FIRST=1: shift left, new bit enters the LSB.
    - MSB_FIRST=0: shift right, new bit enters the MSB.
    - Otherwise bit_cnt+1; after the 8th sample (bit_cnt==7) -> STOP.
  - STOP: when tick_cnt==CLKS_PER_BIT-1, sample s.
    - s=1 and rx_valid=0: dout<=shift register, rx_valid<=1 on the next edge -> IDLE.
    - s=1 and rx_valid=1, rx_ready=0: overrun pulses, new byte is dropped, dout is unchanged -> IDLE.
    - s=1 and rx_valid=1, rx_ready=1 in the same cycle: the old byte is accepted and the new byte is loaded, rx_valid stays 1, no overrun.
    - s=0: frame_err pulses, byte is discarded -> WAIT_IDLE.
  - WAIT_IDLE: stay until s=1 (break or stuck-low line), then -> IDLE. A falling edge is not armed until s has been seen high.
- All samples land at bit centre ±1 cycle: start is checked at HALF_BIT cycles after the detected edge; each later sample follows one CLKS_PER_BIT after the previous one.
- Handshake:
  - rx_valid stays high until a cycle with rx_valid=1 and rx_ready=1; it clears on the following edge unless a new byte loads in that same cycle.
  - rx_ready while rx_valid=0 is ignored.
  - dout holds its last value after rx_valid clears.
- Back-to-back frames: a new falling edge is accepted in IDLE on the first cycle after STOP. No extra idle time is required beyond the stop bit.
- Latency: rx_valid rises 1 cycle after the stop-bit sample edge. From the sin falling edge that is roughly 2 (sync) + HALF_BIT + 9·CLKS_PER_BIT cycles.
- frame_err and overrun never assert in the same cycle; neither asserts in IDLE.

Test Plan:
- CLKS_PER_BIT=6, MSB_FIRST=1, rx_ready=1; drive frame 0,1,0,1,0,0,1,0,1,1 at 6 cycles/bit -> single rx_valid with dout=8'hA5, frame_err=0, overrun=0, busy_rx high from START through STOP.
- MSB_FIRST=0, send 8'h3C LSB-first -> dout=8'h3C. Then send 8'h00 and 8'hFF back-to-back with no idle gap -> two rx_valid events, values 00 then FF.
- 2-cycle low glitch on sin while idle -> returns to IDLE from START; no rx_valid, no flags; a following valid frame 8'h5A is received correctly.
- Frame 8'h81 with stop bit driven 0, then sin held low 20 cycles, then high -> frame_err pulses once, rx_valid stays 0, busy_rx high until sin returns high, next frame 8'h42 is received.
- rx_ready=0; send 8'h11 then 8'h22 -> rx_valid=1 with dout=8'h11, overrun pulses at the second stop sample. Raise rx_ready -> rx_valid clears, dout stays 8'h11.
- Assert nrst=0 during data bit 4 of a frame, release, send 8'hC3 -> all outputs at reset values during reset, no flags, then dout=8'hC3 with rx_valid.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART 8N1 receiver with mid-bit sampling and valid/ready output
//
// Purpose: receives 8N1 frames from an asynchronous serial line, samples each bit
// near its centre with a cycle counter, and hands the byte to downstream logic
// on a valid/ready interface. Framing errors and overruns raise 1-cycle pulses.
//
// Ports:
//   fpga_clk  - system clock
//   nrst      - synchronous active-low reset
//   sin       - asynchronous serial line, idles high
//   rx_ready  - consumer accepts dout while rx_valid=1
//   dout      - received byte, held while rx_valid=1 and after it clears
//   rx_valid  - byte available
//   frame_err - 1-cycle pulse when the stop bit is sampled low
//   overrun   - 1-cycle pulse when a good frame completes but the held byte is not taken
//   busy_rx   - high whenever the receiver is not idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 6,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic       fpga_clk,
  input  logic       nrst,
  input  logic       sin,
  input  logic       rx_ready,
  output logic [7:0] dout,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy_rx
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q;
  logic          s_q;       // synchronized line
  logic          sprev_q;   // previous s_q, for falling-edge detection
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      s_q     <= 1'b1;
      sprev_q <= 1'b1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sin;
      s_q     <= sync1_q;
      sprev_q <= s_q;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // Handshake completes here; a byte loading in the same cycle re-asserts below.
    if (valid_q && rx_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sprev_q && !s_q) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (tick_q == HALF_LAST) begin
          if (s_q) begin
            state_d = S_IDLE;   // line went back high: glitch, not a start bit
          end else begin
            state_d = S_DATA;
            tick_d  = '0;
            bit_d   = '0;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = MSB_FIRST ? {shift_q[6:0], s_q} : {s_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (s_q) begin
            state_d = S_IDLE;
            // Load when the holding register is empty or being emptied this cycle.
            if (!valid_q || rx_ready) begin
              dout_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_WAIT_IDLE: begin
        // Stay until the line is seen high so a held-low line cannot re-trigger.
        if (s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dout      = dout_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy_rx   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  localparam int CPB = 6;

  logic       fpga_clk = 1'b0;
  logic       nrst     = 1'b0;
  logic       sin_m    = 1'b1;
  logic       sin_l    = 1'b1;
  logic       rx_ready = 1'b1;

  logic [7:0] m_dout, l_dout;
  logic       m_valid, m_ferr, m_ovr, m_busy;
  logic       l_valid, l_ferr, l_ovr, l_busy;

  int errors = 0;
  int checks = 0;

  always #5 fpga_clk = ~fpga_clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dut_m (
    .fpga_clk (fpga_clk), .nrst (nrst), .sin (sin_m), .rx_ready (rx_ready),
    .dout (m_dout), .rx_valid (m_valid), .frame_err (m_ferr), .overrun (m_ovr),
    .busy_rx (m_busy)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0)) dut_l (
    .fpga_clk (fpga_clk), .nrst (nrst), .sin (sin_l), .rx_ready (rx_ready),
    .dout (l_dout), .rx_valid (l_valid), .frame_err (l_ferr), .overrun (l_ovr),
    .busy_rx (l_busy)
  );

  // Event monitor: counts rising rx_valid, flag pulses and busy cycles.
  int         m_vcnt = 0, m_fcnt = 0, m_ocnt = 0, m_bcnt = 0;
  int         l_vcnt = 0, l_fcnt = 0, l_ocnt = 0;
  int         both_cnt = 0;
  logic       m_vprev = 1'b0, l_vprev = 1'b0;
  logic [7:0] m_q[$];
  logic [7:0] l_q[$];

  always @(negedge fpga_clk) begin
    if (m_valid && !m_vprev) begin m_vcnt++; m_q.push_back(m_dout); end
    if (l_valid && !l_vprev) begin l_vcnt++; l_q.push_back(l_dout); end
    m_vprev = m_valid;
    l_vprev = l_valid;
    if (m_ferr) m_fcnt++;
    if (m_ovr)  m_ocnt++;
    if (m_busy) m_bcnt++;
    if (l_ferr) l_fcnt++;
    if (l_ovr)  l_ocnt++;
    if ((m_ferr && m_ovr) || (l_ferr && l_ovr)) both_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge fpga_clk);
    #1;
  endtask

  task automatic drive_bit(input bit lsb_inst, input logic v);
    if (lsb_inst) sin_l = v; else sin_m = v;
    idle(CPB);
  endtask

  task automatic send_frame(input bit lsb_inst, input logic [7:0] b, input logic stop);
    drive_bit(lsb_inst, 1'b0);
    for (int i = 0; i < 8; i++)
      drive_bit(lsb_inst, lsb_inst ? b[i] : b[7-i]);
    drive_bit(lsb_inst, stop);
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    idle(3);
    checks++; if (m_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", m_dout); end
    checks++; if ({m_valid, m_ferr, m_ovr, m_busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {m_valid, m_ferr, m_ovr, m_busy}); end
    checks++; if ({l_valid, l_ferr, l_ovr, l_busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags_l: got %b want 0000", {l_valid, l_ferr, l_ovr, l_busy}); end
    nrst = 1'b1;
    idle(4);
  endtask

  task automatic test_basic_msb;
    int v0 = m_vcnt, f0 = m_fcnt, o0 = m_ocnt, b0 = m_bcnt;
    send_frame(1'b0, 8'hA5, 1'b1);
    // Stop-bit sample edge was the last edge of the stop bit; rx_valid is up now.
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: rx_valid got %b want 1", m_valid); end
    checks++; if (m_dout !== 8'hA5) begin errors++; $display("FAIL basic_dout: got %h want a5", m_dout); end
    idle(1);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_ack: rx_valid got %b want 0", m_valid); end
    idle(4);
    checks++; if (m_vcnt - v0 !== 1) begin errors++; $display("FAIL basic_vcnt: got %0d want 1", m_vcnt - v0); end
    checks++; if ((m_fcnt - f0) + (m_ocnt - o0) !== 0) begin errors++; $display("FAIL basic_flags: got %0d want 0", (m_fcnt - f0) + (m_ocnt - o0)); end
    // START (HALF_BIT=3) + 8 data + stop = 3 + 9*6 cycles busy.
    checks++; if (m_bcnt - b0 !== 57) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 57", m_bcnt - b0); end
  endtask

  task automatic test_lsb_back_to_back;
    int v0 = l_vcnt, qi = l_q.size();
    send_frame(1'b1, 8'h3C, 1'b1);
    idle(4);
    checks++; if (l_vcnt - v0 !== 1) begin errors++; $display("FAIL lsb_vcnt: got %0d want 1", l_vcnt - v0); end
    checks++; if (l_dout !== 8'h3C) begin errors++; $display("FAIL lsb_dout: got %h want 3c", l_dout); end
    v0 = l_vcnt;
    qi = l_q.size();
    send_frame(1'b1, 8'h00, 1'b1);
    send_frame(1'b1, 8'hFF, 1'b1);
    idle(4);
    checks++; if (l_vcnt - v0 !== 2) begin errors++; $display("FAIL b2b_vcnt: got %0d want 2", l_vcnt - v0); end
    if (l_q.size() >= qi + 2) begin
      checks++; if (l_q[qi] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", l_q[qi]); end
      checks++; if (l_q[qi+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", l_q[qi+1]); end
    end
    checks++; if (l_fcnt + l_ocnt !== 0) begin errors++; $display("FAIL b2b_flags: got %0d want 0", l_fcnt + l_ocnt); end
  endtask

  task automatic test_glitch;
    int v0 = m_vcnt, f0 = m_fcnt, o0 = m_ocnt;
    sin_m = 1'b0;
    idle(2);
    sin_m = 1'b1;
    idle(12);
    checks++; if (m_vcnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", m_vcnt - v0); end
    checks++; if ((m_fcnt - f0) + (m_ocnt - o0) !== 0) begin errors++; $display("FAIL glitch_flags: got %0d want 0", (m_fcnt - f0) + (m_ocnt - o0)); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy got %b want 0", m_busy); end
    send_frame(1'b0, 8'h5A, 1'b1);
    idle(4);
    checks++; if (m_vcnt - v0 !== 1) begin errors++; $display("FAIL glitch_next_vcnt: got %0d want 1", m_vcnt - v0); end
    checks++; if (m_dout !== 8'h5A) begin errors++; $display("FAIL glitch_next_dout: got %h want 5a", m_dout); end
  endtask

  task automatic test_frame_err;
    int v0 = m_vcnt, f0 = m_fcnt;
    send_frame(1'b0, 8'h81, 1'b0);
    idle(20);
    checks++; if (m_fcnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", m_fcnt - f0); end
    checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low: got %b want 1", m_busy); end
    checks++; if (m_vcnt - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", m_vcnt - v0); end
    sin_m = 1'b1;
    idle(4);
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b want 0", m_busy); end
    send_frame(1'b0, 8'h42, 1'b1);
    idle(4);
    checks++; if (m_dout !== 8'h42) begin errors++; $display("FAIL ferr_next_dout: got %h want 42", m_dout); end
    checks++; if (m_fcnt - f0 !== 1) begin errors++; $display("FAIL ferr_no_extra: got %0d want 1", m_fcnt - f0); end
  endtask

  task automatic test_overrun;
    int v0 = m_vcnt, o0 = m_ocnt;
    rx_ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    idle(4);
    checks++; if (m_ocnt - o0 !== 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", m_ocnt - o0); end
    checks++; if (m_vcnt - v0 !== 1) begin errors++; $display("FAIL ovr_vcnt: got %0d want 1", m_vcnt - v0); end
    checks++; if ({m_valid, m_dout} !== {1'b1, 8'h11}) begin errors++; $display("FAIL ovr_hold: got %b/%h want 1/11", m_valid, m_dout); end
    rx_ready = 1'b1;
    idle(2);
    checks++; if ({m_valid, m_dout} !== {1'b0, 8'h11}) begin errors++; $display("FAIL ovr_release: got %b/%h want 0/11", m_valid, m_dout); end
  endtask

  task automatic test_reset_mid_frame;
    int v0 = m_vcnt, f0 = m_fcnt, o0 = m_ocnt;
    drive_bit(1'b0, 1'b0);               // start
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
    sin_m = 1'b0;                         // data bit 4
    idle(3);
    nrst = 1'b0;
    sin_m = 1'b1;
    idle(3);
    checks++; if (m_dout !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h want 00", m_dout); end
    checks++; if ({m_valid, m_ferr, m_ovr, m_busy} !== 4'b0000) begin errors++; $display("FAIL midrst_flags: got %b want 0000", {m_valid, m_ferr, m_ovr, m_busy}); end
    nrst = 1'b1;
    idle(10);
    checks++; if ((m_vcnt - v0) + (m_fcnt - f0) + (m_ocnt - o0) !== 0) begin errors++; $display("FAIL midrst_events: got %0d want 0", (m_vcnt - v0) + (m_fcnt - f0) + (m_ocnt - o0)); end
    send_frame(1'b0, 8'hC3, 1'b1);
    checks++; if ({m_valid, m_dout} !== {1'b1, 8'hC3}) begin errors++; $display("FAIL midrst_next: got %b/%h want 1/c3", m_valid, m_dout); end
    idle(4);
  endtask

  initial begin
    test_reset;
    test_basic_msb;
    test_lsb_back_to_back;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_reset_mid_frame;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL flags_exclusive: got %0d want 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
